spi_slave_phy: RTL and testbench

SPI_SLAVE_PHY -- requirements
Module: spi_slave_phy

---
 rtl/spi_phy_pkg.sv | 20 ++
 rtl/spi_sync_edge.sv | 40 ++++
 rtl/spi_slave_phy.sv | 177 +++++++++++++++++
 tb/tb_spi_slave_phy.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_phy_pkg.sv
// Shared definitions for the SPI slave PHY: default word width, FSM state
// type and error-counter width.
package spi_phy_pkg;

  localparam int WORD_W_DEF = 16;
  localparam int ERR_CNT_W  = 8;

  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  // Saturating increment used by the optional abort counter.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] val);
    return (val == ERR_CNT_MAX) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, followed by one
// extra flop so that rising and falling edges of the synchronized level can
// be detected in the clk domain. RESET_VAL sets the idle level seen by the
// chain after reset.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_reg [SYNC_STAGES];
  logic prev_reg;

  // Synchronizer chain plus the edge-detect delay flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= RESET_VAL;
      end
      prev_reg <= RESET_VAL;
    end else begin
      sync_reg[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = sync_reg[SYNC_STAGES-1] & ~prev_reg;
  assign fall  = ~sync_reg[SYNC_STAGES-1] & prev_reg;

endmodule

// File: rtl/spi_slave_phy.sv
// SPI mode-0 slave PHY, oversampled by clk (clk >= 8x spi_scl).
// Receives WORD_W-bit words MSB first, transmits tx_data MSB first, and
// reports frame boundaries. Optional abort counter enabled by defining
// SPI_SLAVE_PHY_ERR_CNT_EN; without it err_cnt is tied to 0.
module spi_slave_phy
  import spi_phy_pkg::*;
#(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_scl,
  input  logic                 spi_sdi,
  output logic                 spi_sdo,
  input  logic                 spi_sel,
  output logic [WORD_W-1:0]    rx_data,
  output logic                 rx_valid,
  input  logic [WORD_W-1:0]    tx_data,
  output logic                 tx_load,
  output logic                 frame_start,
  output logic                 frame_end,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  // Synchronized pin views
  logic scl_level, scl_rise, scl_fall;
  logic sel_level, sel_rise, sel_fall;
  logic sdi_s, sdi_rise, sdi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_scl (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spi_scl),
    .level (scl_level),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  // Chip select idles high so reset release never looks like a select.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sel (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spi_sel),
    .level (sel_level),
    .rise  (sel_rise),
    .fall  (sel_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spi_sdi),
    .level (sdi_s),
    .rise  (sdi_rise),
    .fall  (sdi_fall)
  );

  // Only scl/sel edges and the sdi level are needed here.
  logic unused_sync;
  assign unused_sync = ^{scl_level, sel_level, sdi_rise, sdi_fall};

  spi_state_e        state_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [WORD_W-2:0] rx_shift_reg;
  logic [WORD_W-1:0] tx_shift_reg;
  logic [WORD_W-1:0] rx_data_reg;
  logic              rx_valid_reg;
  logic              tx_load_reg;
  logic              frame_start_reg;
  logic              frame_end_reg;

  logic              last_bit;
  logic [WORD_W-1:0] rx_next;

  assign last_bit = (bit_cnt_reg == LAST_BIT);
  assign rx_next  = {rx_shift_reg, sdi_s};

  // Frame FSM with receive/transmit shifters and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      bit_cnt_reg     <= '0;
      rx_shift_reg    <= '0;
      tx_shift_reg    <= '0;
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      tx_load_reg     <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_end_reg   <= 1'b0;
    end else begin
      rx_valid_reg    <= 1'b0;
      tx_load_reg     <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_end_reg   <= 1'b0;

      // tx_data is captured at the end of the cycle tx_load is high. The
      // scl fall right after a word boundary (counter back at 0) must not
      // shift, otherwise the freshly loaded MSB is lost before the master
      // samples it on the next rise.
      if (state_reg == ACTIVE) begin
        if (tx_load_reg) begin
          tx_shift_reg <= tx_data;
        end else if (scl_fall && (bit_cnt_reg != '0)) begin
          tx_shift_reg <= {tx_shift_reg[WORD_W-2:0], 1'b0};
        end
      end

      case (state_reg)
        IDLE: begin
          if (sel_fall) begin
            state_reg       <= ACTIVE;
            frame_start_reg <= 1'b1;
            tx_load_reg     <= 1'b1;
            bit_cnt_reg     <= '0;
            rx_shift_reg    <= '0;
          end
        end
        ACTIVE: begin
          if (scl_rise) begin
            rx_shift_reg <= rx_next[WORD_W-2:0];
            if (last_bit) begin
              bit_cnt_reg  <= '0;
              rx_data_reg  <= rx_next;
              rx_valid_reg <= 1'b1;
              tx_load_reg  <= 1'b1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
          // Deselect ends the frame; a completing last bit in the same
          // cycle has already been captured above, anything partial is lost.
          if (sel_rise) begin
            state_reg     <= IDLE;
            frame_end_reg <= 1'b1;
            bit_cnt_reg   <= '0;
            rx_shift_reg  <= '0;
            tx_shift_reg  <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign spi_sdo     = tx_shift_reg[WORD_W-1];
  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign tx_load     = tx_load_reg;
  assign frame_start = frame_start_reg;
  assign frame_end   = frame_end_reg;

`ifdef SPI_SLAVE_PHY_ERR_CNT_EN
  logic                 abort;
  logic [ERR_CNT_W-1:0] err_cnt_reg;

  assign abort = (state_reg == ACTIVE) && sel_rise && (bit_cnt_reg != '0) &&
                 !(scl_rise && last_bit);

  // Saturating count of words cut short by deselect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= '0;
    end else if (abort) begin
      err_cnt_reg <= sat_inc(err_cnt_reg);
    end
  end

  assign err_cnt = err_cnt_reg;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_spi_slave_phy.sv
// Directed testbench for spi_slave_phy: table of single-word frames plus
// hand-written sequences for multi-word, abort, saturation, idle-scl and
// mid-word reset cases.
module tb_spi_slave_phy;

  localparam int W = 16;
`ifdef SPI_SLAVE_PHY_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         spi_scl;
  logic         spi_sdi;
  logic         spi_sdo;
  logic         spi_sel;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic [W-1:0] tx_data;
  logic         tx_load;
  logic         frame_start;
  logic         frame_end;
  logic [7:0]   err_cnt;

  always #5 clk = ~clk;

  spi_slave_phy #(.WORD_W(W), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_scl     (spi_scl),
    .spi_sdi     (spi_sdi),
    .spi_sdo     (spi_sdo),
    .spi_sel     (spi_sel),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .err_cnt     (err_cnt)
  );

  // Pulse monitor (monotonic counters, tests take deltas)
  int           rx_cnt = 0;
  int           txl_cnt = 0;
  int           fs_cnt = 0;
  int           fe_cnt = 0;
  logic [W-1:0] rx_log [0:1023];

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rx_valid) begin
        rx_log[rx_cnt % 1024] = rx_data;
        rx_cnt++;
      end
      if (tx_load)     txl_cnt++;
      if (frame_start) fs_cnt++;
      if (frame_end)   fe_cnt++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sel_low();
    spi_sel = 1'b0;
    wait_clk(10);
  endtask

  task automatic sel_high();
    wait_clk(8);
    spi_sel = 1'b1;
    wait_clk(12);
  endtask

  // Send the top nbits of w MSB first, recording sdo just before each rise.
  task automatic send_bits(input logic [W-1:0] w, input int nbits, output logic [W-1:0] sdo_seen);
    sdo_seen = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_sdi = w[W-1-i];
      wait_clk(4);
      sdo_seen[W-1-i] = spi_sdo;
      spi_scl = 1'b1;
      wait_clk(8);
      spi_scl = 1'b0;
      wait_clk(4);
    end
  endtask

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] tx;
    logic [W-1:0] exp_rx;
    logic [W-1:0] exp_sdo;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int           b_rx, b_txl, b_fs, b_fe;
    logic [W-1:0] sdo_seen;
    logic [W-1:0] w;
    logic         sdo_hi;

    vecs[0] = '{word: 16'hA55A, tx: 16'h5AA5, exp_rx: 16'hA55A, exp_sdo: 16'h5AA5};
    vecs[1] = '{word: 16'h0000, tx: 16'hFFFF, exp_rx: 16'h0000, exp_sdo: 16'hFFFF};
    vecs[2] = '{word: 16'hFFFF, tx: 16'h0000, exp_rx: 16'hFFFF, exp_sdo: 16'h0000};
    vecs[3] = '{word: 16'h1357, tx: 16'h8001, exp_rx: 16'h1357, exp_sdo: 16'h8001};

    rst_n   = 1'b0;
    spi_scl = 1'b0;
    spi_sdi = 1'b0;
    spi_sel = 1'b1;
    tx_data = '0;
    wait_clk(4);

    // Reset state
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_tx_load", tx_load, 0);
    check("reset_frame_start", frame_start, 0);
    check("reset_frame_end", frame_end, 0);
    check("reset_sdo", spi_sdo, 0);
    check("reset_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    wait_clk(10);
    check("no_start_after_reset", fs_cnt, 0);

    // Single-word frames from the table
    for (int v = 0; v < 4; v++) begin
      b_rx = rx_cnt; b_txl = txl_cnt; b_fs = fs_cnt; b_fe = fe_cnt;
      tx_data = vecs[v].tx;
      sel_low();
      send_bits(vecs[v].word, W, sdo_seen);
      sel_high();
      $display("frame %0d: sent %h tx %h rx %h sdo %h", v, vecs[v].word, vecs[v].tx, rx_data, sdo_seen);
      check("vec_rx_valid_cnt", rx_cnt - b_rx, 1);
      check("vec_rx_data", rx_log[b_rx % 1024], {16'h0, vecs[v].exp_rx});
      check("vec_sdo", sdo_seen, {16'h0, vecs[v].exp_sdo});
      check("vec_frame_start", fs_cnt - b_fs, 1);
      check("vec_frame_end", fe_cnt - b_fe, 1);
      check("vec_tx_load", txl_cnt - b_txl, 2);
    end

    // Three back-to-back words in one frame
    b_rx = rx_cnt; b_txl = txl_cnt; b_fs = fs_cnt; b_fe = fe_cnt;
    tx_data = 16'h1111;
    sel_low();
    send_bits(16'h0001, W, sdo_seen);
    send_bits(16'h8000, W, sdo_seen);
    send_bits(16'hFFFF, W, sdo_seen);
    sel_high();
    $display("frame multi: words 0001 8000 ffff rx_valid %0d tx_load %0d", rx_cnt - b_rx, txl_cnt - b_txl);
    check("multi_rx_valid_cnt", rx_cnt - b_rx, 3);
    check("multi_word0", rx_log[(b_rx + 0) % 1024], 16'h0001);
    check("multi_word1", rx_log[(b_rx + 1) % 1024], 16'h8000);
    check("multi_word2", rx_log[(b_rx + 2) % 1024], 16'hFFFF);
    check("multi_tx_load", txl_cnt - b_txl, 4);
    check("multi_frame_start", fs_cnt - b_fs, 1);
    check("multi_frame_end", fe_cnt - b_fe, 1);

    // Last-bit scl rise and sel rise detected in the same cycle
    b_rx = rx_cnt; b_fe = fe_cnt;
    w = 16'h6C39;
    tx_data = 16'h0F0F;
    sel_low();
    send_bits(w, W - 1, sdo_seen);
    spi_sdi = w[0];
    wait_clk(4);
    spi_scl = 1'b1;
    spi_sel = 1'b1;
    wait_clk(12);
    spi_scl = 1'b0;
    wait_clk(10);
    $display("frame simul: sent %h rx %h err_cnt %0d", w, rx_data, err_cnt);
    check("simul_rx_valid_cnt", rx_cnt - b_rx, 1);
    check("simul_rx_data", rx_log[b_rx % 1024], 16'h6C39);
    check("simul_frame_end", fe_cnt - b_fe, 1);
    check("simul_no_abort", err_cnt, 0);
    check("simul_sdo_idle", spi_sdo, 0);

    // Abort after 7 bits, then a full frame
    b_rx = rx_cnt; b_fe = fe_cnt;
    sel_low();
    send_bits(16'hFF00, 7, sdo_seen);
    sel_high();
    $display("frame abort7: rx_valid %0d frame_end %0d err_cnt %0d", rx_cnt - b_rx, fe_cnt - b_fe, err_cnt);
    check("abort_no_rx_valid", rx_cnt - b_rx, 0);
    check("abort_frame_end", fe_cnt - b_fe, 1);
    check("abort_err_cnt", err_cnt, ERR_EN ? 1 : 0);
    check("abort_rx_data_hold", rx_data, 16'h6C39);
    b_rx = rx_cnt;
    tx_data = 16'hE718;
    sel_low();
    send_bits(16'hC3A5, W, sdo_seen);
    sel_high();
    $display("frame after_abort: sent c3a5 rx %h sdo %h", rx_data, sdo_seen);
    check("after_abort_rx_cnt", rx_cnt - b_rx, 1);
    check("after_abort_rx_data", rx_log[b_rx % 1024], 16'hC3A5);
    check("after_abort_sdo", sdo_seen, 16'hE718);

    // 260 further aborted frames: counter saturates
    for (int k = 0; k < 260; k++) begin
      sel_low();
      send_bits(16'h8000, 1, sdo_seen);
      sel_high();
      if (k == 252) check("err_cnt_254", err_cnt, ERR_EN ? 254 : 0);
    end
    $display("frame abort_burst: err_cnt %0d", err_cnt);
    check("err_cnt_saturated", err_cnt, ERR_EN ? 255 : 0);

    // scl toggling while deselected is ignored
    b_rx = rx_cnt; b_txl = txl_cnt;
    sdo_hi = 1'b0;
    for (int k = 0; k < 16; k++) begin
      spi_sdi = k[0];
      spi_scl = 1'b1;
      wait_clk(8);
      sdo_hi |= spi_sdo;
      spi_scl = 1'b0;
      wait_clk(8);
      sdo_hi |= spi_sdo;
    end
    $display("idle_scl: rx_valid %0d tx_load %0d sdo_hi %0d", rx_cnt - b_rx, txl_cnt - b_txl, sdo_hi);
    check("idle_no_rx_valid", rx_cnt - b_rx, 0);
    check("idle_no_tx_load", txl_cnt - b_txl, 0);
    check("idle_sdo_low", sdo_hi, 0);

    // Reset pulse after 9 bits
    tx_data = 16'hFFFF;
    sel_low();
    send_bits(16'hFFFF, 9, sdo_seen);
    rst_n = 1'b0;
    wait_clk(2);
    check("midrst_rx_data", rx_data, 0);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_tx_load", tx_load, 0);
    check("midrst_frame_start", frame_start, 0);
    check("midrst_frame_end", frame_end, 0);
    check("midrst_sdo", spi_sdo, 0);
    check("midrst_err_cnt", err_cnt, 0);
    spi_sel = 1'b1;
    spi_scl = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    b_rx = rx_cnt; b_txl = txl_cnt; b_fs = fs_cnt; b_fe = fe_cnt;
    wait_clk(30);
    check("midrst_quiet", (rx_cnt - b_rx) + (txl_cnt - b_txl) + (fs_cnt - b_fs) + (fe_cnt - b_fe), 0);
    tx_data = 16'h0F0F;
    sel_low();
    send_bits(16'h1234, W, sdo_seen);
    sel_high();
    $display("frame post_reset: sent 1234 rx %h sdo %h", rx_data, sdo_seen);
    check("post_reset_rx_cnt", rx_cnt - b_rx, 1);
    check("post_reset_rx_data", rx_data, 16'h1234);
    check("post_reset_sdo", sdo_seen, 16'h0F0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
